// File: rtl/ta_pkg.sv
// Shared types and memory-map constants for the token-attention virtual-memory responder.
package ta_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        SERVE = 2'd3
    } ta_state_e;

    // Weight blocks follow the token words; offsets are relative to L.
    localparam int TA_ROW_WORDS = 8;
    localparam int TA_WQ_OFS    = 0;
    localparam int TA_WK_OFS    = TA_WQ_OFS + TA_ROW_WORDS;
    localparam int TA_WV_OFS    = TA_WK_OFS + TA_ROW_WORDS;
    localparam int TA_W_ROWS    = TA_WV_OFS + TA_ROW_WORDS;

    function automatic logic [6:0] ta_tok_words(input logic [1:0] len);
        ta_tok_words = 7'd4 << len;
    endfunction

endpackage

// File: rtl/ta_vmem_ram.sv
// DEPTH x DW word store: one synchronous write port, one asynchronous read port.
module ta_vmem_ram #(
    parameter int DEPTH = 64,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; a read in the write cycle sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ta_vmem.sv
// Memory-side responder for the TA core: loads a job's tokens and weights, then serves reads.
// Optional read-address checking (rd_err output) is enabled with `define TA_VMEM_ADDR_CHK_EN.
module ta_vmem
    import ta_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int DW       = 32,
    parameter int OUT_ROWS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    input  logic [1:0]               i_length,
    input  logic                     h_valid,
    input  logic [DW-1:0]            h_data,
    output logic                     h_ready,
    input  logic                     m_read,
    input  logic [$clog2(DEPTH)-1:0] m_addr,
    output logic [DW-1:0]            m_data,
    output logic                     m_ready,
    input  logic                     o_valid,
    output logic                     busy
`ifdef TA_VMEM_ADDR_CHK_EN
    ,
    output logic                     rd_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(OUT_ROWS + 1);

    ta_state_e     state_q, state_d;
    logic [1:0]    len_q, len_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [AW:0]   n_words;
    logic          last_word;
    logic          beat_last;
    logic          wr_fire;
    logic [DW-1:0] ram_rdata;

    assign n_words   = (AW+1)'(ta_tok_words(len_q)) + (AW+1)'(TA_W_ROWS);
    assign last_word = ({1'b0, wr_ptr_q} == (n_words - (AW+1)'(1)));
    assign beat_last = (beat_cnt_q == BW'(OUT_ROWS - 1));
    assign wr_fire   = (state_q == LOAD) && h_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_valid) state_d = LOAD;
            LOAD:    if (h_valid && last_word) state_d = READY;
            READY:   state_d = SERVE;
            SERVE:   if (o_valid && beat_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        h_ready = 1'b0;
        m_ready = 1'b0;
        busy    = 1'b1;
        unique case (state_q)
            IDLE:    busy    = 1'b0;
            LOAD:    h_ready = 1'b1;
            READY:   m_ready = 1'b1;
            SERVE:   ;
            default: busy    = 1'b0;
        endcase
    end

    // Job bookkeeping: length, write pointer and output-row count.
    always_comb begin
        len_d      = len_q;
        wr_ptr_d   = wr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    len_d      = i_length;
                    wr_ptr_d   = '0;
                    beat_cnt_d = '0;
                end
            end
            LOAD:    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
            SERVE:   if (o_valid) beat_cnt_d = beat_cnt_q + BW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            wr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            len_q      <= len_d;
            wr_ptr_q   <= wr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    ta_vmem_ram #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr_q),
        .wdata (h_data),
        .raddr (m_addr),
        .rdata (ram_rdata)
    );

    // The TA core registers m_data at the next edge, so the read path stays combinational.
    assign m_data = m_read ? ram_rdata : '0;

`ifdef TA_VMEM_ADDR_CHK_EN
    logic rd_err_q, rd_err_d;

    always_comb begin
        rd_err_d = rd_err_q;
        if (state_q == IDLE && i_valid) begin
            rd_err_d = 1'b0;
        end
        if (m_read && ((state_q != SERVE) || ({1'b0, m_addr} >= n_words))) begin
            rd_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_err_q <= 1'b0;
        end else begin
            rd_err_q <= rd_err_d;
        end
    end

    assign rd_err = rd_err_q;
`endif

endmodule

// File: tb/tb_ta_vmem.sv
// Self-checking bench for ta_vmem: table of load jobs with a readback scoreboard, plus reset/corner sequences.
module tb_ta_vmem;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic [1:0]  i_length;
    logic        h_valid;
    logic [31:0] h_data;
    logic        h_ready;
    logic        m_read;
    logic [5:0]  m_addr;
    logic [31:0] m_data;
    logic        m_ready;
    logic        o_valid;
    logic        busy;
`ifdef TA_VMEM_ADDR_CHK_EN
    logic        rd_err;
`endif

    ta_vmem #(.DEPTH(64), .DW(32), .OUT_ROWS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_length (i_length),
        .h_valid  (h_valid),
        .h_data   (h_data),
        .h_ready  (h_ready),
        .m_read   (m_read),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .o_valid  (o_valid),
        .busy     (busy)
`ifdef TA_VMEM_ADDR_CHK_EN
        ,
        .rd_err   (rd_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mdl [64];
    int          mdl_hi = 0;
    logic [31:0] sb_q [$];

    typedef struct {
        logic [1:0] len;
        bit         gaps;
        int         exp_n;
        int         exp_lat;
    } vec_t;

    vec_t vecs [5];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        int          ready_cyc;
        int          pulses;
        int          k;
        bit          hr_bad;
        logic [31:0] w;
        logic [31:0] e;

        @(negedge clk);
        i_valid  = 1'b1;
        i_length = v.len;
        #1;
        check1("busy_idle_before_job", busy, 1'b0);
        ready_cyc = -1;
        pulses    = 0;
        k         = 0;
        hr_bad    = 0;
        for (int t = 1; t <= 400; t++) begin
            @(negedge clk);
            i_valid = 1'b0;
            if (k < v.exp_n && (!v.gaps || (t % 2 == 1))) begin
                w = (v.len == 2'd0 && !v.gaps) ? 32'(k) : $urandom;
                h_valid = 1'b1;
                h_data  = w;
                sb_q.push_back(w);
                mdl[k] = w;
                k++;
            end else begin
                h_valid = 1'b0;
            end
            #1;
            if (h_valid && !h_ready) hr_bad = 1;
            if (m_ready) begin
                pulses++;
                if (ready_cyc < 0) ready_cyc = t;
            end
            if (ready_cyc >= 0 && t >= ready_cyc + 2) break;
        end
        h_valid = 1'b0;
        if (v.exp_n > mdl_hi) mdl_hi = v.exp_n;
        checki("h_ready_during_load", int'(hr_bad), 0);
        checki($sformatf("m_ready_latency_len%0d_gaps%0d", v.len, v.gaps), ready_cyc, v.exp_lat);
        checki("m_ready_pulse_count", pulses, 1);
        check1("busy_in_serve", busy, 1'b1);
        check1("h_ready_in_serve", h_ready, 1'b0);

        for (int a = 0; a < v.exp_n; a++) begin
            @(negedge clk);
            m_read = 1'b1;
            m_addr = 6'(a);
            #1;
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
            check32($sformatf("readback[%0d]", a), m_data, e);
        end
        if (v.len == 2'd0 && !v.gaps) begin
            @(negedge clk);
            m_addr = 6'd20;
            #1;
            check32("read_addr20_same_cycle", m_data, 32'h0000_0014);
        end
        @(negedge clk);
        m_read = 1'b0;
        #1;
        check32("m_data_gated_by_m_read", m_data, 32'h0);

        // seven output rows, with host words offered that must be dropped
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            o_valid = 1'b1;
            h_valid = 1'b1;
            h_data  = 32'hDEAD_0000 | 32'(i);
        end
        @(negedge clk);
        o_valid  = 1'b0;
        h_valid  = 1'b0;
        i_valid  = 1'b1;
        i_length = ~v.len;
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        check1("ivalid_ignored_busy", busy, 1'b1);
        check1("ivalid_ignored_h_ready", h_ready, 1'b0);
        @(negedge clk);
        o_valid = 1'b1;
        @(negedge clk);
        o_valid = 1'b0;
        #1;
        check1("busy_after_8th_row", busy, 1'b0);
        check1("h_ready_after_8th_row", h_ready, 1'b0);
        if (mdl_hi > v.exp_n) begin
            m_read = 1'b1;
            m_addr = 6'(v.exp_n);
            #1;
            check32("dropped_host_word", m_data, mdl[v.exp_n]);
            m_read = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pulses;
        logic [31:0] w;

        vecs[0] = '{len: 2'd3, gaps: 1'b0, exp_n: 56, exp_lat: 57};
        vecs[1] = '{len: 2'd0, gaps: 1'b0, exp_n: 28, exp_lat: 29};
        vecs[2] = '{len: 2'd1, gaps: 1'b0, exp_n: 32, exp_lat: 33};
        vecs[3] = '{len: 2'd3, gaps: 1'b1, exp_n: 56, exp_lat: 112};
        vecs[4] = '{len: 2'd2, gaps: 1'b1, exp_n: 40, exp_lat: 80};

        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_length = 2'd0;
        h_valid  = 1'b0;
        h_data   = 32'h0;
        m_read   = 1'b0;
        m_addr   = 6'd0;
        o_valid  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check1("reset_h_ready", h_ready, 1'b0);
        check1("reset_m_ready", m_ready, 1'b0);
        check1("reset_busy", busy, 1'b0);
        check32("reset_m_data", m_data, 32'h0);
`ifdef TA_VMEM_ADDR_CHK_EN
        check1("reset_rd_err", rd_err, 1'b0);
`endif
        h_valid = 1'b1;
        h_data  = 32'hBAD0_BAD0;
        @(negedge clk);
        h_valid = 1'b0;
        #1;
        check1("idle_host_word_ignored", busy, 1'b0);

        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i]);
        end

        // stale read in IDLE after a finished job
        @(negedge clk);
        m_read = 1'b1;
        m_addr = 6'd5;
        #1;
        check32("idle_stale_read", m_data, mdl[5]);
        check1("idle_stale_m_ready", m_ready, 1'b0);
        m_read = 1'b0;

        // reset during LOAD after 10 words; also read-during-write at the same address
        @(negedge clk);
        i_valid  = 1'b1;
        i_length = 2'd2;
        @(negedge clk);
        i_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            w       = $urandom;
            h_valid = 1'b1;
            h_data  = w;
            m_read  = 1'b1;
            m_addr  = 6'(k);
            #1;
            if (k < 3) check32($sformatf("rw_same_addr_old[%0d]", k), m_data, mdl[k]);
            mdl[k] = w;
            @(negedge clk);
        end
        m_read  = 1'b0;
        h_valid = 1'b1;
        h_data  = 32'h5555_AAAA;
        #2;
        rst_n = 1'b0;
        #1;
        check1("midjob_reset_h_ready", h_ready, 1'b0);
        check1("midjob_reset_busy", busy, 1'b0);
        h_valid = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            #1;
            if (m_ready) pulses++;
        end
        checki("midjob_reset_no_m_ready", pulses, 0);
        for (int a = 0; a < 13; a++) begin
            @(negedge clk);
            m_read = 1'b1;
            m_addr = 6'(a);
            #1;
            check32($sformatf("partial_contents[%0d]", a), m_data, mdl[a]);
        end
        @(negedge clk);
        m_read = 1'b0;

`ifdef TA_VMEM_ADDR_CHK_EN
        // address check: N=32, read at 32 in SERVE flags and holds until the next accepted job
        begin
            int rdy;
            @(negedge clk);
            i_valid  = 1'b1;
            i_length = 2'd1;
            @(negedge clk);
            i_valid = 1'b0;
            #1;
            check1("rd_err_cleared_on_job", rd_err, 1'b0);
            rdy = -1;
            for (int t = 0; t < 200; t++) begin
                if (t < 32) begin
                    h_valid = 1'b1;
                    h_data  = $urandom;
                end else begin
                    h_valid = 1'b0;
                end
                @(negedge clk);
                #1;
                if (m_ready) begin
                    rdy = t;
                    break;
                end
            end
            h_valid = 1'b0;
            checki("chk_job_m_ready_seen", int'(rdy >= 0), 1);
            @(negedge clk);
            m_read = 1'b1;
            m_addr = 6'd31;
            @(negedge clk);
            #1;
            check1("rd_err_in_range", rd_err, 1'b0);
            m_addr = 6'd32;
            @(negedge clk);
            m_read = 1'b0;
            #1;
            check1("rd_err_set_out_of_range", rd_err, 1'b1);
            @(negedge clk);
            #1;
            check1("rd_err_held", rd_err, 1'b1);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                o_valid = 1'b1;
            end
            @(negedge clk);
            o_valid = 1'b0;
            #1;
            check1("rd_err_held_in_idle", rd_err, 1'b1);
            i_valid  = 1'b1;
            i_length = 2'd0;
            @(negedge clk);
            i_valid = 1'b0;
            #1;
            check1("rd_err_cleared_by_ivalid", rd_err, 1'b0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ta_vmem.md
# ta_vmem

Virtual-memory responder for the token-attention (TA) accelerator: the memory-side end of the `m_read`/`m_addr`/`m_data`/`m_ready` interface. It captures a job length from `i_valid`/`i_length`, accepts a host stream of 32-bit words (tokens, then WQ, WK and WV rows) and writes them into a 64×32 store. It then pulses `m_ready` and serves the accelerator's combinational reads until the accelerator has emitted its 8 output rows. It sits between the testbench/host loader and the TA core.

## Interface
Parameters:
- `DEPTH`, 64: words in store; address width is `$clog2(DEPTH)` = 6.
- `DW`, 32: word width.
- `OUT_ROWS`, 8: `o_valid` beats that end a job.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  job start, shared with the TA core.
- `i_length`  in  2  token-count code: L = 4 << `i_length` (4/8/16/32).
- `h_valid`  in  1  host word valid.
- `h_data`  in  32  host word.
- `h_ready`  out  1  block accepts a host word this cycle.
- `m_read`  in  1  TA read strobe.
- `m_addr`  in  6  TA read address.
- `m_data`  out  32  read data.
- `m_ready`  out  1  store loaded; one-cycle pulse.
- `o_valid`  in  1  TA output-row valid, monitored only.
- `busy`  out  1  state != IDLE.

## Operation
- Memory map for a job of L tokens:
  - tokens at 0..L-1, MSB nibble = element 0;
  - WQ at L..L+7;
  - WK at L+8..L+15;
  - WV at L+16..L+23.
  - Total N = L+24 words (28/32/40/56). N never exceeds 64.
- States:
  - IDLE: `h_ready`=0. `i_valid`=1 latches `len`=`i_length`, clears `wr_ptr` and `beat_cnt`, and moves to LOAD.
  - LOAD: `h_ready`=1. Each `h_valid`&&`h_ready` writes `mem[wr_ptr]`=`h_data` and increments `wr_ptr`. The write with `wr_ptr`==N-1 moves to READY; the host is stalled while `h_valid`=0.
  - READY: `m_ready`=1 for this single cycle, `h_ready`=0; moves to SERVE unconditionally.
  - SERVE: `h_ready`=0. Each `o_valid`=1 cycle increments `beat_cnt`; the cycle with `beat_cnt`==OUT_ROWS-1 and `o_valid`=1 moves to IDLE.
- Read path is combinational: `m_data` = `mem[m_addr]` when `m_read`=1, else 0. It is valid in the same cycle as `m_addr`, because the TA core registers it at the next edge.
- `i_valid` outside IDLE is ignored and does not re-latch `len`.
- `h_valid` outside LOAD is dropped with no write.
- A write and a read to the same address in one cycle return the old contents; the write lands at the edge.
- Store contents are not reset. Only control state is reset.

## Timing
- Reset values:
  - state IDLE;
  - `h_ready`=0, `m_ready`=0, `busy`=0;
  - `m_data`=0 while `m_read`=0;
  - `wr_ptr`=0, `beat_cnt`=0, `len`=0.
- Reset mid-job returns to IDLE immediately and asynchronously. No `m_ready` is produced, and partial contents stay in the store.
- `i_valid` at edge t puts LOAD in effect from t+1, so `h_ready`=1 in cycle t+1.
- The last word accepted at edge t gives `m_ready`=1 in cycle t+1 only, and SERVE from t+2.
- Zero-wait-state host: `m_ready` comes N+1 cycles after the `i_valid` cycle.
- The 8th `o_valid` beat at edge t gives IDLE and `busy`=0 in cycle t+1. A new `i_valid` is accepted from that cycle.

## Configuration
- `TA_VMEM_ADDR_CHK_EN` defined:
  - adds output `rd_err` (1 bit, reset 0);
  - `rd_err` is sticky-set by `m_read`=1 in any state other than SERVE, or by `m_addr` >= N;
  - `rd_err` is cleared by `i_valid` accepted in IDLE;
  - a flagged read still returns `mem[m_addr]`.
- Macro undefined: no `rd_err` port and no check logic. All other behaviour is identical.

## Structure
- `ta_pkg` holds:
  - the state enum (IDLE, LOAD, READY, SERVE);
  - `TA_WQ_OFS`=0, `TA_WK_OFS`=8, `TA_WV_OFS`=16, relative to L;
  - `TA_W_ROWS`=24;
  - function `ta_tok_words(len)` = 4 << len.
- Sub-module `ta_vmem_ram`: DEPTH×DW array with synchronous write port and asynchronous read port. The FSM, pointers and check logic stay in `ta_vmem`.

## Test plan
- Reset then idle: `m_read`=1, `m_addr`=5 → `m_data` = stale contents; `m_ready`=0, `h_ready`=0, `busy`=0.
- `i_length`=0, stream words 0x00000000..0x0000001B with no gaps → `m_ready` high exactly one cycle, 29 cycles after `i_valid`. Then `m_addr`=20, `m_read`=1 → `m_data`=0x00000014 in the same cycle.
- `i_length`=3 with `h_valid` toggling 1/0 → 56 writes, `wr_ptr` reaches 56 and `m_ready` follows the 56th accepted word. `m_addr`=55 returns the last word.
- SERVE with 7 `o_valid` pulses, then `i_valid` → ignored, `busy`=1. The 8th pulse → IDLE next cycle, and the next `i_valid` is accepted.
- Assert `rst_n`=0 in LOAD after 10 words → `h_ready`=0 and state IDLE immediately; no `m_ready` ever pulses for that job.
- With `TA_VMEM_ADDR_CHK_EN`, `i_length`=1: SERVE read at `m_addr`=32 (N=32) → `rd_err`=1 and held. Next accepted `i_valid` → `rd_err`=0.
